bcd_frac_to_fixed: RTL and testbench



---
 rtl/bcd_frac_pkg.sv | 20 ++
 rtl/frac_serial_div.sv | 68 ++++++
 rtl/bcd_frac_to_fixed.sv | 155 +++++++++++++++
 tb/tb_bcd_frac_to_fixed.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_frac_pkg.sv
// Shared constants and FSM encoding for the decimal-fraction to binary
// fixed-point converter.
package bcd_frac_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int ACC_W      = 20;
  localparam int REM_W      = 21;

  localparam logic [REM_W-1:0] DEC_SCALE  = 21'd1000000;
  localparam logic [REM_W-1:0] HALF_SCALE = 21'd500000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DIVIDE = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/frac_serial_div.sv
// Serial restoring divide of n * 2^FRAC_W by 10^6, one quotient bit per cycle,
// with a combinational round-to-nearest/saturate on the final quotient.
module frac_serial_div
  import bcd_frac_pkg::*;
#(
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ACC_W-1:0]  n,
  output logic              done,
  output logic [FRAC_W-1:0] q
);

  localparam int CNT_W = $clog2(FRAC_W) + 1;

  logic [REM_W-1:0]  rem;
  logic [REM_W-1:0]  rem2;
  logic [FRAC_W-1:0] quo;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic              round_up;

  // rem stays below 10^6, so doubling never overflows REM_W bits
  always_comb begin
    rem2 = {rem[REM_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= REM_W'(n);
      quo  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      if (rem2 >= DEC_SCALE) begin
        rem <= rem2 - DEC_SCALE;
        quo <= {quo[FRAC_W-2:0], 1'b1};
      end else begin
        rem <= rem2;
        quo <= {quo[FRAC_W-2:0], 1'b0};
      end
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(FRAC_W - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // 2r >= 10^6 is the same test as r >= 10^6/2
  always_comb begin
    round_up = (rem >= HALF_SCALE);
    q        = quo;
    if (round_up && !(&quo)) begin
      q = quo + FRAC_W'(1);
    end
  end

endmodule

// File: rtl/bcd_frac_to_fixed.sv
// Six-digit decimal fraction to FRAC_W-bit binary fraction, rounded to nearest.
// Define ASCII_DIGITS_EN to accept ASCII '0'..'9' digit bytes instead of binary BCD.
module bcd_frac_to_fixed
  import bcd_frac_pkg::*;
#(
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        tenths,
  input  logic [7:0]        hundredths,
  input  logic [7:0]        thousandths,
  input  logic [7:0]        ten_thousandths,
  input  logic [7:0]        hundred_thousandths,
  input  logic [7:0]        millionths,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] frac,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid with frac/err holds until out_ready is seen.

  state_t state, state_n;

  logic [7:0]       in_bytes [NUM_DIGITS];
  logic [3:0]       in_vals  [NUM_DIGITS];
  logic [3:0]       digs     [NUM_DIGITS];
  logic             any_bad;
  logic             bad;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [2:0]       cnt;
  logic             div_start;
  logic             div_done;
  logic [FRAC_W-1:0] div_q;

  function automatic logic digit_ok(input logic [7:0] b);
`ifdef ASCII_DIGITS_EN
    return (b >= 8'h30) && (b <= 8'h39);
`else
    return (b <= 8'h09);
`endif
  endfunction

  assign in_bytes[0] = tenths;
  assign in_bytes[1] = hundredths;
  assign in_bytes[2] = thousandths;
  assign in_bytes[3] = ten_thousandths;
  assign in_bytes[4] = hundred_thousandths;
  assign in_bytes[5] = millionths;

  // Invalid digits contribute zero so N stays inside 0..999999 for the divider.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_vals[i] = digit_ok(in_bytes[i]) ? in_bytes[i][3:0] : 4'd0;
      any_bad    = any_bad | ~digit_ok(in_bytes[i]);
    end
  end

  always_comb begin
    acc_next = (acc << 3) + (acc << 1) + ACC_W'(digs[cnt]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_n = ACCUM;
      end
      ACCUM: begin
        if (cnt == 3'(NUM_DIGITS - 1)) begin
          div_start = 1'b1;
          state_n   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) state_n = ROUND;
      end
      ROUND: begin
        state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digs[i] <= '0;
      bad  <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      frac <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            digs <= in_vals;
            bad  <= any_bad;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          cnt <= cnt + 3'd1;
        end
        ROUND: begin
          frac <= bad ? '0 : div_q;
          err  <= bad;
        end
        default: begin
        end
      endcase
    end
  end

  frac_serial_div #(
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .n     (acc_next),
    .done  (div_done),
    .q     (div_q)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_bcd_frac_to_fixed.sv
// Directed bench for bcd_frac_to_fixed at FRAC_W=16, plus a FRAC_W=4 instance
// for the narrow saturation case.
module tb_bcd_frac_to_fixed;
  import bcd_frac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid4 = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_ready4 = 1'b1;
  logic [7:0]  tenths = '0, hundredths = '0, thousandths = '0;
  logic [7:0]  ten_thousandths = '0, hundred_thousandths = '0, millionths = '0;
  logic        in_ready, out_valid, err;
  logic [15:0] frac;
  logic [2:0]  dbg_state;
  logic        in_ready4, out_valid4, err4;
  logic [3:0]  frac4;
  logic [2:0]  dbg_state4;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int prev_acc = 0;
  logic [16:0] exp_q[$];

  bcd_frac_to_fixed #(.FRAC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .tenths(tenths), .hundredths(hundredths), .thousandths(thousandths),
    .ten_thousandths(ten_thousandths), .hundred_thousandths(hundred_thousandths),
    .millionths(millionths), .out_valid(out_valid), .out_ready(out_ready),
    .frac(frac), .err(err), .dbg_state(dbg_state)
  );

  bcd_frac_to_fixed #(.FRAC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .tenths(tenths), .hundredths(hundredths), .thousandths(thousandths),
    .ten_thousandths(ten_thousandths), .hundred_thousandths(hundred_thousandths),
    .millionths(millionths), .out_valid(out_valid4), .out_ready(out_ready4),
    .frac(frac4), .err(err4), .dbg_state(dbg_state4)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int d);
`ifdef ASCII_DIGITS_EN
    return 8'(d + 'h30);
`else
    return 8'(d);
`endif
  endfunction

  function automatic logic [47:0] digs6(input int a, b, c, d, e, f);
    return {enc(a), enc(b), enc(c), enc(d), enc(e), enc(f)};
  endfunction

  task automatic put_digits(input logic [47:0] v);
    {tenths, hundredths, thousandths, ten_thousandths, hundred_thousandths, millionths} = v;
  endtask

  task automatic scramble();
    put_digits({$urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535)});
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one FRAC_W=16 conversion; called with the bench sitting 1 time unit after an edge.
  task automatic convert(input string tag, input logic [47:0] v, input logic [15:0] ef,
                         input logic ee, input int stall, input bit chk_ii);
    int lat;
    int busy_rdy;
    int unstable;
    logic [16:0] exp;
    out_ready = (stall == 0);
    wait_ready();
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    put_digits(v);
    in_valid = 1'b1;
    exp_q.push_back({ee, ef});
    @(posedge clk); #1;
    if (chk_ii) check({tag, "_ii"}, 32'(cyc - prev_acc), 32'd26);
    prev_acc = cyc;
    in_valid = 1'b0;
    scramble();
    lat = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy++;
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd24);
    check({tag, "_busy_ready"}, 32'(busy_rdy), 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_frac"}, 32'(frac), 32'(exp[15:0]));
    check({tag, "_err"}, 32'(err), 32'(exp[16]));
    if (stall > 0) begin
      unstable = 0;
      repeat (stall) begin
        @(posedge clk); #1;
        if (frac !== exp[15:0] || err !== exp[16] || !out_valid || in_ready) unstable++;
      end
      check({tag, "_stall_hold"}, 32'(unstable), 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  task automatic convert4(input string tag, input logic [47:0] v, input logic [3:0] ef);
    int lat;
    for (int i = 0; i < 60 && !in_ready4; i++) begin
      @(posedge clk); #1;
    end
    put_digits(v);
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    scramble();
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd12);
    check({tag, "_frac"}, 32'(frac4), 32'(ef));
    check({tag, "_err"}, 32'(err4), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] bad_byte;
    logic [7:0] bad_hi;
`ifdef ASCII_DIGITS_EN
    bad_byte = 8'h09;
    bad_hi   = 8'h3A;
`else
    bad_byte = 8'h0A;
    bad_hi   = 8'h13;
`endif

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frac", 32'(frac), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // back-to-back with out_ready high
    convert("half",   digs6(5,0,0,0,0,0), 16'h8000, 1'b0, 0, 1'b0);
    convert("tenth",  digs6(1,0,0,0,0,0), 16'h199A, 1'b0, 0, 1'b1);
    convert("rnd_up", digs6(0,0,0,0,0,8), 16'h0001, 1'b0, 0, 1'b1);
    convert("one_u",  digs6(0,0,0,0,0,1), 16'h0000, 1'b0, 0, 1'b1);
    convert("seven_u",digs6(0,0,0,0,0,7), 16'h0000, 1'b0, 0, 1'b1);
    convert("sat",    digs6(9,9,9,9,9,9), 16'hFFFF, 1'b0, 0, 1'b1);
    convert("third",  digs6(3,3,3,3,3,3), 16'h5555, 1'b0, 0, 1'b1);
    convert("c000",   digs6(7,5,0,0,0,0), 16'hC000, 1'b0, 0, 1'b1);
    convert("r15",    digs6(0,0,0,0,1,5), 16'h0001, 1'b0, 0, 1'b1);
    convert("zero",   digs6(0,0,0,0,0,0), 16'h0000, 1'b0, 0, 1'b1);

    // invalid digits still take full latency
    convert("bad_lsd", {digs6(5,0,0,0,0,0) & 48'hFFFF_FFFF_FF00} | 48'(bad_byte), 16'h0000, 1'b1, 0, 1'b0);
    convert("bad_msd", {bad_hi, 40'h0} | (digs6(0,2,0,0,0,0) & 48'h00FF_FFFF_FFFF), 16'h0000, 1'b1, 0, 1'b0);
    convert("good_after_bad", digs6(2,5,0,0,0,0), 16'h4000, 1'b0, 0, 1'b0);

    // output stall
    convert("stall", digs6(1,2,3,4,5,6), 16'h1F9B, 1'b0, 10, 1'b0);

    // narrow instance
    convert4("w4_sat",  digs6(9,6,9,0,0,0), 4'hF);
    convert4("w4_half", digs6(5,0,0,0,0,0), 4'h8);

    // reset in the middle of DIVIDE
    wait_ready();
    put_digits(digs6(9,9,9,9,9,9));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_state", 32'(dbg_state), 32'(DIVIDE));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_frac", 32'(frac), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    #1;
    check("abort_release_ready", 32'(in_ready), 32'd1);
    convert("after_abort", digs6(2,5,0,0,0,0), 16'h4000, 1'b0, 0, 1'b0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
